// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table controller: default index
// width, the counter value a sweep writes, the controller state encoding and
// the 2-bit saturating counter update.
package bht_pkg;

    localparam int         BHT_IDX_W    = 10;
    localparam logic [1:0] BHT_INIT_CTR = 2'b01;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bht_state_e;

    // Taken moves the counter toward strongly-taken, not-taken toward
    // strongly-not-taken; both ends saturate.
    function automatic logic [1:0] bht_sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO holding pending {index, taken} branch updates.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is ignored even if a pop happens in the same cycle.
module bht_upd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer bookkeeping; clear and reset both drop every queued entry.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + ONE;
            if (w_do_pop)  r_rptr <= r_rptr + ONE;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller.
// After reset or a flush it sweeps every table entry to INIT_CTR while
// predictions are gated off, then applies queued branch-resolution updates
// through a two-stage read-modify-write pipeline (stage A reads and computes,
// stage B writes).
// Optional feature: define BHT_CTRL_FWD_EN to forward stage B's write data
// into stage A on a same-index hazard; otherwise stage A stalls one cycle.
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int         IDX_W      = BHT_IDX_W,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_CTR   = BHT_INIT_CTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic             flush_req,
    output logic             busy,
    output logic             pred_gate,
    output logic [IDX_W-1:0] tbl_rd_idx,
    input  logic [1:0]       tbl_rd_data,
    output logic             tbl_wr_en,
    output logic [IDX_W-1:0] tbl_wr_idx,
    output logic [1:0]       tbl_wr_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    bht_state_e       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_b_vld;
    logic [IDX_W-1:0] r_b_idx;
    logic [1:0]       r_b_ctr;
    logic [IDX_W-1:0] r_hold_idx;
    logic [1:0]       r_hold_data;

    logic             w_run;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_clear;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [IDX_W:0]   w_fifo_head;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic             w_hazard;
    logic             w_stall;
    logic [1:0]       w_ctr_base;
    logic             w_unused_pc;

    // PC bits outside the index field do not select a table entry.
    assign w_unused_pc  = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign w_run        = !rst && (r_state == RUN);
    assign upd_ready    = w_run && !w_fifo_full;
    assign w_push       = upd_valid && upd_ready;
    assign w_fifo_clear = w_run && flush_req;

    assign busy         = rst || (r_state == SWEEP);
    assign pred_gate    = busy;

    assign w_head_idx   = w_fifo_head[IDX_W:1];
    assign w_head_taken = w_fifo_head[0];
    assign tbl_rd_idx   = w_head_idx;

    // The table read in stage A is stale when stage B is about to write the
    // same entry at the coming edge.
    assign w_hazard     = r_b_vld && (w_head_idx == r_b_idx);
`ifdef BHT_CTRL_FWD_EN
    assign w_stall      = 1'b0;
    assign w_ctr_base   = w_hazard ? r_b_ctr : tbl_rd_data;
`else
    assign w_stall      = w_hazard;
    assign w_ctr_base   = tbl_rd_data;
`endif
    assign w_pop        = w_run && !w_fifo_empty && !w_stall;

    bht_upd_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_fifo_clear),
        .i_push      (w_push),
        .i_push_data ({upd_pc[IDX_W+1:2], upd_taken}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Controller state: sweep all entries once, then run until a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SWEEP: begin
                    if (flush_req) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                        if (r_cnt == LAST_IDX) r_state <= RUN;
                    end
                end
                RUN: begin
                    if (flush_req) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= SWEEP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stage B valid: set by a stage A pop, dropped by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || w_fifo_clear) begin
            r_b_vld <= 1'b0;
        end else begin
            r_b_vld <= w_pop;
        end
    end

    // Stage A -> stage B: capture the index and its updated counter.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_b_idx <= w_head_idx;
            r_b_ctr <= bht_sat_next(w_ctr_base, w_head_taken);
        end
    end

    // Remember the last write so the write port holds steady when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_idx  <= '0;
            r_hold_data <= 2'b00;
        end else if (tbl_wr_en) begin
            r_hold_idx  <= tbl_wr_idx;
            r_hold_data <= tbl_wr_data;
        end
    end

    // Table write port: sweep writes win; otherwise stage B writes.
    always_comb begin
        tbl_wr_en   = 1'b0;
        tbl_wr_idx  = r_hold_idx;
        tbl_wr_data = r_hold_data;
        if (!rst) begin
            if (r_state == SWEEP) begin
                tbl_wr_en   = 1'b1;
                tbl_wr_idx  = r_cnt;
                tbl_wr_data = INIT_CTR;
            end else if (r_b_vld) begin
                tbl_wr_en   = 1'b1;
                tbl_wr_idx  = r_b_idx;
                tbl_wr_data = r_b_ctr;
            end
        end
    end

endmodule

// File: doc/bht_ctrl.md
BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 Parameter IDX_W, default 10: BHT index width; index = upd_pc[IDX_W+1:2].
REQ-002 Parameter FIFO_DEPTH, default 4: update queue entries (power of two, >=2).
REQ-003 Parameter INIT_CTR, default 2'b01: counter value written by a sweep (weakly not taken).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 upd_valid  in  1  branch-resolution update offered.
REQ-007 upd_ready  out  1  update accepted when upd_valid && upd_ready.
REQ-008 upd_pc  in  32  PC of resolved branch.
REQ-009 upd_taken  in  1  resolved direction (1 = taken).
REQ-010 flush_req  in  1  single-cycle pulse: reinitialise whole table.
REQ-011 busy  out  1  sweep in progress.
REQ-012 pred_gate  out  1  fetch treats every prediction as not-taken while 1.
REQ-013 tbl_rd_idx  out  IDX_W  table read index (combinational read).
REQ-014 tbl_rd_data  in  2  counter at tbl_rd_idx, same cycle.
REQ-015 tbl_wr_en / tbl_wr_idx / tbl_wr_data  out  1 / IDX_W / 2  table write port, committed at the next rising edge.

Function
REQ-016 FSM states SWEEP and RUN; reset enters SWEEP with sweep counter 0.
REQ-017 SWEEP: each cycle tbl_wr_en=1, tbl_wr_idx=counter, tbl_wr_data=INIT_CTR; counter increments by 1.
REQ-018 SWEEP -> RUN on the cycle after the write of index 2^IDX_W-1 (exactly 2^IDX_W write cycles).
REQ-019 busy = pred_gate = (state == SWEEP).
REQ-020 upd_ready = (state == RUN) && FIFO not full; no same-cycle push when full, even if a pop occurs.
REQ-021 Accepted updates are pushed as {index, taken}, processed strictly in order.
REQ-022 Stage A (RUN, FIFO non-empty, no stall): drives tbl_rd_idx = head index, pops head, registers index and next counter into stage B.
REQ-023 Next counter: 2-bit saturating; taken -> +1 capped at 2'b11, not taken -> -1 floored at 2'b00.
REQ-024 Stage B: when valid, drives tbl_wr_en=1 with its index and counter for one cycle.
REQ-025 Latency: update accepted at edge t into an empty FIFO -> tbl_wr_en high in cycle t+2.
REQ-026 Throughput: one update per cycle when no same-index hazard.
REQ-027 Hazard: stage A index equals valid stage B index in the same cycle; handled per Configuration.
REQ-028 flush_req in RUN: next cycle state = SWEEP, counter = 0, FIFO emptied, stage B invalidated; a stage-B write in the flush_req cycle still commits.
REQ-029 flush_req during SWEEP restarts the counter at 0.
REQ-030 When neither SWEEP nor a valid stage B: tbl_wr_en = 0; tbl_wr_idx/tbl_wr_data hold previous values.

Reset
REQ-031 rst=1 at an edge: state SWEEP, counter 0, FIFO empty, stage B invalid, tbl_wr_en 0, tbl_wr_idx 0, tbl_wr_data 0.
REQ-032 While rst=1: upd_ready 0, busy 1, pred_gate 1, tbl_wr_en 0; first sweep write occurs in the first cycle with rst=0.
REQ-033 rst mid-sweep or mid-update discards all progress and pending updates.

Configuration
REQ-034 Macro BHT_CTRL_FWD_EN defined: on a hazard, stage A uses stage B's tbl_wr_data instead of tbl_rd_data; no stall.
REQ-035 BHT_CTRL_FWD_EN undefined: on a hazard, stage A does not pop for that cycle and retries in the next cycle; final table contents are identical in both builds.

Structure
REQ-036 Package bht_pkg holds IDX_W default, INIT_CTR, the state enum (SWEEP, RUN) and the saturating-counter next-value function.
REQ-037 Sub-module bht_upd_fifo (synchronous FIFO, FIFO_DEPTH x (IDX_W+1), push/pop/full/empty/clear) is instantiated once.

Verification
REQ-038 Release rst -> writes to idx 0..1023 with data 01 over 1024 cycles, busy drops in cycle 1025, upd_ready rises with it.
REQ-039 In RUN, tbl_rd_data=01, update pc=0x40 taken -> cycle t+2 write idx 16 data 10.
REQ-040 Back-to-back updates pc=0x40 taken, taken with table entry 01 -> writes 10 then 11; FWD build takes 2 consecutive cycles, non-FWD build has a 1-cycle gap.
REQ-041 Saturation: entry 11 taken -> write 11; entry 00 not taken -> write 00.
REQ-042 Issue 5 updates with no pops possible (force hazard stall) -> upd_ready low after 4 queued, 5th held until space.
REQ-043 flush_req with 3 queued updates -> none written, sweep restarts at idx 0, busy=1 next cycle.
